multicycle_controller: RTL

Multicycle, handshake-aware successor to the single-cycle model-machine controller. It sequences each instruction through FETCH and EXEC states and stretches memory accesses with a `mem_ready` handshake. It also adds a memory watchdog, single-step mode, a halt/restart state and a retired-instruction counter. It sits between the instruction register/flag logic and the PC, RAM, register file and AU of the parametrised model machine.

---
 rtl/multicycle_controller.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// Multicycle model-machine controller: FETCH/EXEC sequencing with a mem_ready
// handshake, memory watchdog, single-step pause, halt/restart and a
// retired-instruction counter.
module multicycle_controller #(
  parameter int RA_W    = 2,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  step_mode,
  input  logic                  step,
  input  logic [4+2*RA_W-1:0]   ir,
  input  logic                  gf,
  input  logic                  mem_ready,
  output logic                  ld_pc,
  output logic                  in_pc,
  output logic                  ram_re,
  output logic                  ram_we,
  output logic                  ld_ir,
  output logic                  reg_we,
  output logic                  au_en,
  output logic                  g_en,
  output logic                  in_en,
  output logic                  out_en,
  output logic                  s0,
  output logic [1:0]            s,
  output logic [3:0]            ac,
  output logic [RA_W-1:0]       SR,
  output logic [RA_W-1:0]       DR,
  output logic                  halted,
  output logic                  fault,
  output logic [2:0]            state,
  output logic [CNT_W-1:0]      instr_cnt
);

  localparam int IR_W = 4 + 2*RA_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_PAUSE = 3'd3,
    S_HALT  = 3'd4,
    S_FAULT = 3'd5
  } state_t;

  localparam logic [3:0] OP_MOVA = 4'b0100;
  localparam logic [3:0] OP_MOVB = 4'b0101;
  localparam logic [3:0] OP_MOVC = 4'b0110;
  localparam logic [3:0] OP_MOVD = 4'b0111;
  localparam logic [3:0] OP_ADD  = 4'b1000;
  localparam logic [3:0] OP_SUB  = 4'b1001;
  localparam logic [3:0] OP_JMP  = 4'b1010;
  localparam logic [3:0] OP_JG   = 4'b1011;
  localparam logic [3:0] OP_IN   = 4'b1100;
  localparam logic [3:0] OP_OUT  = 4'b1101;
  localparam logic [3:0] OP_MOVI = 4'b1110;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [3:0] AC_MOV = 4'b0100;
  localparam logic [3:0] AC_ADD = 4'b1000;
  localparam logic [3:0] AC_SUB = 4'b1001;

  // Fixed register address 3 (zero-extended for wider register files)
  localparam logic [RA_W-1:0] REG3 = RA_W'(2'b11);
  localparam logic [7:0]      TO   = 8'(TIMEOUT);

  state_t           st, st_nx;
  logic [7:0]       wcnt;
  logic [3:0]       op;
  logic [RA_W-1:0]  rd, rs;
  logic             mem_op, waiting, timeout, exec_done;

  assign op = ir[IR_W-1 -: 4];
  assign rd = ir[2*RA_W-1 -: RA_W];
  assign rs = ir[RA_W-1:0];

  assign mem_op    = (op == OP_MOVB) || (op == OP_MOVC) || (op == OP_MOVI);
  // Cycles in which the controller is stalled on the RAM handshake
  assign waiting   = (st == S_FETCH) || ((st == S_EXEC) && mem_op);
  assign timeout   = waiting && !mem_ready && (wcnt == TO);
  assign exec_done = (st == S_EXEC) && (!mem_op || mem_ready);

  // State register, watchdog counter and retired-instruction counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= S_IDLE;
      wcnt      <= '0;
      instr_cnt <= '0;
    end else begin
      st <= st_nx;
      // Any state change starts a fresh access window
      if (st_nx != st)
        wcnt <= '0;
      else if (waiting && !mem_ready)
        wcnt <= wcnt + 8'd1;
      if (exec_done)
        instr_cnt <= instr_cnt + 1'b1;
    end
  end

  // Next-state decode; mem_ready wins over an expiring watchdog
  always_comb begin
    st_nx = st;
    case (st)
      S_IDLE:  if (start) st_nx = S_FETCH;
      S_FETCH: begin
        if (mem_ready)    st_nx = S_EXEC;
        else if (timeout) st_nx = S_FAULT;
      end
      S_EXEC: begin
        if (exec_done) begin
          if (op == OP_HALT)  st_nx = S_HALT;
          else if (step_mode) st_nx = S_PAUSE;
          else                st_nx = S_FETCH;
        end else if (timeout) begin
          st_nx = S_FAULT;
        end
      end
      S_PAUSE: if (step)  st_nx = S_FETCH;
      S_HALT,
      S_FAULT: if (start) st_nx = S_FETCH;
      default: st_nx = S_IDLE;
    endcase
  end

  // Datapath strobes decoded from registered state, ir, gf and mem_ready
  always_comb begin
    ld_pc  = 1'b0;
    in_pc  = 1'b0;
    ram_re = 1'b0;
    ram_we = 1'b0;
    ld_ir  = 1'b0;
    reg_we = 1'b0;
    au_en  = 1'b0;
    g_en   = 1'b0;
    in_en  = 1'b0;
    out_en = 1'b0;
    s0     = 1'b1;
    s      = 2'b00;
    ac     = 4'b0000;
    SR     = '0;
    DR     = '0;
    case (st)
      S_FETCH: begin
        ram_re = 1'b1;
        ld_ir  = mem_ready;
        in_pc  = mem_ready;
      end
      S_EXEC: begin
        SR = rs;
        DR = rd;
        case (op)
          OP_MOVA: begin au_en = 1'b1; ac = AC_MOV; reg_we = 1'b1; end
          OP_MOVB: begin ram_we = 1'b1; s = 2'b10; au_en = 1'b1; ac = AC_MOV; end
          OP_MOVC: begin ram_re = 1'b1; s = 2'b01; reg_we = mem_ready; end
          OP_MOVD: begin reg_we = 1'b1; s0 = 1'b0; SR = REG3; DR = REG3; end
          OP_ADD:  begin au_en = 1'b1; ac = AC_ADD; reg_we = 1'b1; end
          OP_SUB:  begin au_en = 1'b1; ac = AC_SUB; reg_we = 1'b1; g_en = 1'b1; end
          OP_JMP:  begin ld_pc = 1'b1; SR = REG3; end
          OP_JG:   begin ld_pc = gf; SR = REG3; end
          OP_IN:   begin reg_we = 1'b1; in_en = 1'b1; end
          OP_OUT:  begin au_en = 1'b1; ac = AC_MOV; out_en = 1'b1; end
          OP_MOVI: begin ram_re = 1'b1; reg_we = mem_ready; in_pc = mem_ready; DR = '0; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign halted = (st == S_HALT);
  assign fault  = (st == S_FAULT);
  assign state  = st;

endmodule
